// File: rtl/icache.sv
// Direct-mapped read-only I-cache: 0-cycle hit; a miss stalls fetch (dp_ihit=0) while a one-word refill waits on mem_iwait.
// Define ICACHE_STATS_EN to add the 32-bit hit_count/miss_count ports.
module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dp_imemREN,
  input  logic [31:0] dp_imemaddr,
  output logic        dp_ihit,
  output logic [31:0] dp_imemload,
  output logic        mem_iREN,
  output logic [31:0] mem_iaddr,
  input  logic        mem_iwait,
  input  logic [31:0] mem_iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {IDLE, FETCH} state_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   dat;
  } frame_t;

  state_t          state;
  logic [SETS-1:0] valid;
  frame_t          frames [SETS];
  logic [31:0]     miss_addr;
  logic            mem_iren_q;
  logic [31:0]     mem_iaddr_q;

  logic [IW-1:0]   req_idx;
  logic [IW-1:0]   fill_idx;
  logic [TW-1:0]   req_tag;
  logic            hit;
  logic            miss;
  logic            fill;
  logic            unused_bits;

  assign req_idx  = dp_imemaddr[IW+1:2];
  assign req_tag  = dp_imemaddr[31:IW+2];
  assign fill_idx = miss_addr[IW+1:2];

  // Compare only in IDLE: a redirect during refill must not produce a hit.
  assign hit  = (state == IDLE) && dp_imemREN && valid[req_idx] &&
                (frames[req_idx].tag == req_tag);
  assign miss = (state == IDLE) && dp_imemREN && !hit;
  assign fill = (state == FETCH) && !mem_iwait;

  assign dp_ihit     = hit;
  assign dp_imemload = hit ? frames[req_idx].dat : 32'h0;
  assign mem_iREN    = mem_iren_q;
  assign mem_iaddr   = mem_iaddr_q;

  assign unused_bits = ^{dp_imemaddr[1:0], miss_addr[1:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      valid       <= '0;
      miss_addr   <= 32'h0;
      mem_iren_q  <= 1'b0;
      mem_iaddr_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            miss_addr   <= dp_imemaddr;
            mem_iaddr_q <= {dp_imemaddr[31:2], 2'b00};
            mem_iren_q  <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (!mem_iwait) begin
            valid[fill_idx] <= 1'b1;
            mem_iren_q      <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces IDLE asynchronously, so fill is false and no frame is written under reset.
  always_ff @(posedge CLK) begin
    if (fill) begin
      frames[fill_idx] <= '{tag: miss_addr[31:IW+2], dat: mem_iload};
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      hit_count  <= hit_count + {31'h0, hit};
      miss_count <= miss_count + {31'h0, miss};
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against a frame-level reference model.
module tb_icache;
  localparam int SETS = 16;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dp_imemREN = 1'b0;
  logic [31:0] dp_imemaddr = 32'h0;
  logic        dp_ihit;
  logic [31:0] dp_imemload;
  logic        mem_iREN;
  logic [31:0] mem_iaddr;
  logic        mem_iwait = 1'b1;
  logic [31:0] mem_iload = 32'h0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int errors = 0;
  int checks = 0;

  bit          m_vld  [SETS];
  logic [29:0] m_word [SETS];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  icache #(.SETS(SETS)) dut (
    .CLK(CLK), .nRST(nRST),
    .dp_imemREN(dp_imemREN), .dp_imemaddr(dp_imemaddr),
    .dp_ihit(dp_ihit), .dp_imemload(dp_imemload),
    .mem_iREN(mem_iREN), .mem_iaddr(mem_iaddr),
    .mem_iwait(mem_iwait), .mem_iload(mem_iload)
`ifdef ICACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h0000_0000: return 32'h3C01_0004;
      32'h0000_0040: return 32'h8C22_0000;
      default:       return w * 32'h9E37_79B1 + 32'h0123_4567;
    endcase
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned idx;
    idx = (a >> 2) % SETS;
    return m_vld[idx] && (m_word[idx] == a[31:2]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int unsigned idx;
    idx = (a >> 2) % SETS;
    m_vld[idx]  = 1'b1;
    m_word[idx] = a[31:2];
  endfunction

  task automatic do_reset();
    nRST = 1'b0;
    dp_imemREN = 1'b0;
    mem_iwait = 1'b1;
    for (int i = 0; i < SETS; i++) m_vld[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  // One fetch: hit in the same cycle, or miss + (waits+1) refill cycles + hit.
  task automatic do_fetch(input logic [31:0] a, input int waits);
    @(posedge CLK); #1;
    dp_imemREN = 1'b1;
    dp_imemaddr = a;
    mem_iwait = 1'b1;
    @(negedge CLK);
    if (model_hit(a)) begin
      exp_hits++;
      checks++;
      if (dp_ihit !== 1'b1 || dp_imemload !== mem_word(a) || mem_iREN !== 1'b0) begin
        errors++;
        $display("FAIL hit a=%h: ihit=%b load=%h iREN=%b, want 1 %h 0", a, dp_ihit, dp_imemload, mem_iREN, mem_word(a));
      end
    end else begin
      exp_misses++;
      checks++;
      if (dp_ihit !== 1'b0 || dp_imemload !== 32'h0 || mem_iREN !== 1'b0) begin
        errors++;
        $display("FAIL miss_detect a=%h: ihit=%b load=%h iREN=%b, want 0 0 0", a, dp_ihit, dp_imemload, mem_iREN);
      end
      for (int k = 0; k <= waits; k++) begin
        @(posedge CLK); #1;
        mem_iwait = (k < waits);
        mem_iload = (k == waits) ? mem_word(a) : $urandom;
        @(negedge CLK);
        checks++;
        if (mem_iREN !== 1'b1 || mem_iaddr !== {a[31:2], 2'b00} || dp_ihit !== 1'b0 || dp_imemload !== 32'h0) begin
          errors++;
          $display("FAIL refill a=%h k=%0d: iREN=%b iaddr=%h ihit=%b, want 1 %h 0", a, k, mem_iREN, mem_iaddr, dp_ihit, {a[31:2], 2'b00});
        end
      end
      model_fill(a);
      @(posedge CLK); #1;
      mem_iwait = 1'b1;
      mem_iload = $urandom;
      @(negedge CLK);
      exp_hits++;
      checks++;
      if (dp_ihit !== 1'b1 || dp_imemload !== mem_word(a) || mem_iREN !== 1'b0) begin
        errors++;
        $display("FAIL post_fill a=%h: ihit=%b load=%h iREN=%b, want 1 %h 0", a, dp_ihit, dp_imemload, mem_iREN, mem_word(a));
      end
    end
  endtask

  // Idle one cycle so the counters have absorbed every sampled cycle, then compare.
  task automatic test_stats(input string tag);
    @(posedge CLK); #1;
    dp_imemREN = 1'b0;
    @(negedge CLK);
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      errors++;
      $display("FAIL stats_%s: hits=%0d misses=%0d, want %0d %0d", tag, hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
    checks++;
    if (dp_ihit !== 1'b0 || mem_iREN !== 1'b0) begin
      errors++;
      $display("FAIL idle_%s: ihit=%b iREN=%b, want 0 0", tag, dp_ihit, mem_iREN);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #2;
    @(negedge CLK);
    checks++;
    if (dp_ihit !== 1'b0 || dp_imemload !== 32'h0 || mem_iREN !== 1'b0 || mem_iaddr !== 32'h0) begin
      errors++;
      $display("FAIL reset: ihit=%b load=%h iREN=%b iaddr=%h, want all 0", dp_ihit, dp_imemload, mem_iREN, mem_iaddr);
    end
    do_reset();
  endtask

  task automatic test_cold_miss();
    do_fetch(32'h0000_0000, 2);
    test_stats("cold");
  endtask

  task automatic test_warm_hit();
    do_fetch(32'h0000_0000, 0);
    do_fetch(32'h0000_0002, 0);
    do_fetch(32'h0000_0000, 0);
    test_stats("warm");
  endtask

  task automatic test_conflict();
    do_fetch(32'h0000_0040, 1);
    do_fetch(32'h0000_0000, 1);
    test_stats("conflict");
  endtask

  task automatic test_redirect();
    @(posedge CLK); #1;
    dp_imemREN = 1'b1;
    dp_imemaddr = 32'h0000_0010;
    mem_iwait = 1'b1;
    exp_misses++;
    @(negedge CLK);
    checks++;
    if (dp_ihit !== 1'b0) begin
      errors++;
      $display("FAIL redir_miss: ihit=%b, want 0", dp_ihit);
    end
    for (int k = 0; k <= 2; k++) begin
      @(posedge CLK); #1;
      if (k == 0) dp_imemaddr = 32'h0000_0100;
      mem_iwait = (k < 2);
      mem_iload = (k == 2) ? mem_word(32'h10) : $urandom;
      @(negedge CLK);
      checks++;
      if (mem_iREN !== 1'b1 || mem_iaddr !== 32'h0000_0010 || dp_ihit !== 1'b0) begin
        errors++;
        $display("FAIL redir_refill k=%0d: iREN=%b iaddr=%h ihit=%b, want 1 00000010 0", k, mem_iREN, mem_iaddr, dp_ihit);
      end
    end
    model_fill(32'h10);
    @(posedge CLK); #1;
    mem_iwait = 1'b1;
    @(negedge CLK);
    exp_misses++;
    checks++;
    if (model_hit(32'h100) || dp_ihit !== 1'b0 || mem_iREN !== 1'b0) begin
      errors++;
      $display("FAIL redir_newmiss: ihit=%b iREN=%b, want 0 0", dp_ihit, mem_iREN);
    end
    @(posedge CLK); #1;
    mem_iwait = 1'b0;
    mem_iload = mem_word(32'h100);
    @(negedge CLK);
    checks++;
    if (mem_iREN !== 1'b1 || mem_iaddr !== 32'h0000_0100 || dp_ihit !== 1'b0) begin
      errors++;
      $display("FAIL redir_refill2: iREN=%b iaddr=%h ihit=%b, want 1 00000100 0", mem_iREN, mem_iaddr, dp_ihit);
    end
    model_fill(32'h100);
    @(posedge CLK); #1;
    mem_iwait = 1'b1;
    @(negedge CLK);
    exp_hits++;
    checks++;
    if (dp_ihit !== 1'b1 || dp_imemload !== mem_word(32'h100)) begin
      errors++;
      $display("FAIL redir_hit: ihit=%b load=%h, want 1 %h", dp_ihit, dp_imemload, mem_word(32'h100));
    end
    do_fetch(32'h0000_0010, 0);
    test_stats("redirect");
  endtask

  task automatic test_reset_mid_fetch();
    do_fetch(32'h0000_0020, 0);
    @(posedge CLK); #1;
    dp_imemaddr = 32'h0000_0024;
    dp_imemREN = 1'b1;
    mem_iwait = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (mem_iREN !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_fetch: iREN=%b, want 1", mem_iREN);
    end
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (mem_iREN !== 1'b0 || mem_iaddr !== 32'h0 || dp_ihit !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: iREN=%b iaddr=%h ihit=%b, want 0 0 0", mem_iREN, mem_iaddr, dp_ihit);
    end
`ifdef ICACHE_STATS_EN
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_stats: hits=%0d misses=%0d, want 0 0", hit_count, miss_count);
    end
`endif
    do_reset();
    do_fetch(32'h0000_0024, 1);
    do_fetch(32'h0000_0020, 0);
    test_stats("reset_mid");
  endtask

  task automatic test_ren_low();
    do_fetch(32'h0000_0020, 0);
    @(posedge CLK); #1;
    dp_imemREN = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      checks++;
      if (dp_ihit !== 1'b0 || dp_imemload !== 32'h0 || mem_iREN !== 1'b0) begin
        errors++;
        $display("FAIL ren_low k=%0d: ihit=%b load=%h iREN=%b, want 0 0 0", k, dp_ihit, dp_imemload, mem_iREN);
      end
      @(posedge CLK); #1;
    end
    test_stats("ren_low");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int n = 0; n < 200; n++) begin
      a = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
      do_fetch(a, $urandom_range(0, 3));
    end
    test_stats("random");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_reset_mid_fetch();
    test_ren_low();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
